arbitro_ventanas: RTL and testbench
===================================

Name: arbitro_ventanas

Overview:
- Frame-synchronous pixel arbiter that sits downstream of sincronizador (consumes px, py, vidon, vsync).
- Shares the single VGA RGB output between N_SRC pixel sources. Each source owns a configurable rectangular window; the lowest index wins where windows overlap, and a background colour is shown elsewhere.
- Window configuration is written into shadow registers through a write/commit handshake. It becomes active only at a frame boundary, so the picture never tears.

Parameters:
- N_SRC, 3, number of pixel sources/windows (1..4).
- CW, 8, RGB word width per source.
- BG_COLOR, 8'h00, colour driven when vidon=1 and no window hits.

Ports:
- clk  in  1  pixel clock, same clock as sincronizador.
- rst  in  1  asynchronous reset, active-low.
- px  in  10  current pixel column from sincronizador.
- py  in  10  current pixel row from sincronizador.
- vidon  in  1  visible-area flag from sincronizador.
- vsync  in  1  vertical sync, active-low.
- src_rgb  in  N_SRC*CW  concatenated source pixels; source i at [i*CW +: CW].
- cfg_wr  in  1  shadow-register write strobe.
- cfg_idx  in  2  target window index.
- cfg_x0, cfg_x1, cfg_y0, cfg_y1  in  10 each  window bounds, inclusive.
- cfg_en  in  1  window enable.
- cfg_commit  in  1  request to apply the shadow set at the next frame boundary.
- cfg_busy  out  1  commit pending; writes and commits are ignored while high.
- gnt  out  N_SRC  one-hot grant, registered.
- rgb_out  out  CW  arbitrated pixel, registered.
- frame_cnt  out  8  frames elapsed, wraps 255→0.

Behaviour:
- Reset (rst=0, asynchronous): all active and shadow windows cleared (bounds 0, en 0); gnt=0; rgb_out=0; cfg_busy=0; frame_cnt=0; FSM=IDLE; vsync history register=1.
- Frame boundary: registered vsync_d=1 and vsync=0 (falling edge), detected in exactly one clk.
  - frame_cnt increments on each boundary.
- Window hit i: en_i && x0_i<=px<=x1_i && y0_i<=py<=y1_i, unsigned compare.
  - x0>x1 or y0>y1 means the window never hits; this is not an error.
- Arbitration, combinational on the current px/py, then registered:
  - vidon=0 → gnt=0, rgb_out=0.
  - vidon=1, no hit → gnt=0, rgb_out=BG_COLOR.
  - Otherwise the lowest hitting index i wins: gnt[i]=1 and rgb_out=src_rgb[i].
- Latency: gnt/rgb_out reflect the px/py/vidon/src_rgb of the previous cycle, a fixed 1-clk latency.
- Config FSM:
  - IDLE:
    - cfg_wr=1 writes all five fields of shadow[cfg_idx]; cfg_idx>=N_SRC is ignored.
    - cfg_commit=1 → PENDING with cfg_busy=1 from the next cycle.
    - cfg_wr and cfg_commit in the same cycle: the write lands first, then the commit takes effect, so the written data is included.
  - PENDING:
    - cfg_wr and cfg_commit are ignored.
    - On a frame boundary → APPLY.
  - APPLY (one cycle):
    - active ← shadow, all windows at once.
    - cfg_busy falls to 0 in the next cycle; FSM → IDLE.
  - A commit in IDLE during the same cycle as a boundary does not apply in that frame; it waits for the next boundary.
- Active registers change only in APPLY, so arbitration never sees a partial set.
- Reset mid-PENDING: the commit is discarded, and shadow and active both clear.
- Shadow contents persist after APPLY; re-committing without new writes reapplies the same set.

Test Plan:
- Reset and defaults: rst=0 for 3 clk, then release with vidon=1 → rgb_out=BG_COLOR, gnt=0, cfg_busy=0, frame_cnt=0.
- Single window: write window0 = x 100..199, y 50..99, en=1; commit; drive one vsync fall.
  - cfg_busy drops 2 clk after the fall.
  - px=100,py=50 with src0=8'hAA → rgb_out=8'hAA, gnt=3'b001 one clk later.
  - px=200 → BG_COLOR.
- Priority overlap: window0 and window1 both cover (150,60), src1=8'h55, src0=8'hAA → gnt=001, rgb_out=8'hAA.
  - Disable window0 and commit → gnt=010, rgb_out=8'h55 only after the next boundary.
- Tear-free and busy: commit new bounds mid-frame, then write cfg_wr while cfg_busy=1.
  - The ignored write is absent from the shadow set.
  - Old bounds stay in effect until the vsync fall.
- Blanking and empty window: vidon=0 inside window0 → rgb_out=0, gnt=0. A window with x0=300,x1=200 never grants.
- Wrap and reset: 256 vsync falls → frame_cnt=0. Assert rst while PENDING → cfg_busy=0 immediately, active windows cleared.

Source files
------------

// File: rtl/arbitro_ventanas.sv
// -----------------------------------------------------------------------------
// arbitro_ventanas
//
// Frame-synchronous pixel arbiter. It shares one VGA RGB output between
// N_SRC pixel sources. Each source owns a rectangular window. Where windows
// overlap, the lowest index wins. Outside every window, BG_COLOR is shown.
//
// Window settings are written into shadow registers. A commit copies the
// whole shadow set into the active set at the next vsync falling edge, so
// the arbitration logic never sees a partially updated frame.
//
// Ports
//   clk        pixel clock, shared with the sync generator
//   rst        asynchronous reset, active-low
//   px, py     current pixel column and row
//   vidon      visible-area flag
//   vsync      vertical sync, active-low; its falling edge marks a new frame
//   src_rgb    concatenated source pixels; source i is at [i*CW +: CW]
//   cfg_wr     shadow write strobe (fields cfg_idx/x0/x1/y0/y1/en)
//   cfg_commit request to apply the shadow set at the next frame boundary
//   cfg_busy   a commit is pending; writes and commits are ignored
//   gnt        one-hot grant of the winning source, registered
//   rgb_out    arbitrated pixel, registered (1-clk latency)
//   frame_cnt  count of frame boundaries, wraps 255 -> 0
//
// Config FSM
//   state     | meaning
//   S_IDLE    | accepting shadow writes and commits
//   S_PENDING | commit requested, waiting for a frame boundary
//   S_APPLY   | single cycle: active set <= shadow set
// -----------------------------------------------------------------------------
module arbitro_ventanas #(
  parameter int              N_SRC    = 3,
  parameter int              CW       = 8,
  parameter logic [CW-1:0]   BG_COLOR = {CW{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          px,
  input  logic [9:0]          py,
  input  logic                vidon,
  input  logic                vsync,
  input  logic [N_SRC*CW-1:0] src_rgb,
  input  logic                cfg_wr,
  input  logic [1:0]          cfg_idx,
  input  logic [9:0]          cfg_x0,
  input  logic [9:0]          cfg_x1,
  input  logic [9:0]          cfg_y0,
  input  logic [9:0]          cfg_y1,
  input  logic                cfg_en,
  input  logic                cfg_commit,
  output logic                cfg_busy,
  output logic [N_SRC-1:0]    gnt,
  output logic [CW-1:0]       rgb_out,
  output logic [7:0]          frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_APPLY   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic       vsync_d;
  logic       frame_edge;

  logic [9:0] sh_x0 [N_SRC];
  logic [9:0] sh_x1 [N_SRC];
  logic [9:0] sh_y0 [N_SRC];
  logic [9:0] sh_y1 [N_SRC];
  logic       sh_en [N_SRC];

  logic [9:0] act_x0 [N_SRC];
  logic [9:0] act_x1 [N_SRC];
  logic [9:0] act_y0 [N_SRC];
  logic [9:0] act_y1 [N_SRC];
  logic       act_en [N_SRC];

  logic [N_SRC-1:0] hit;
  logic [N_SRC-1:0] gnt_nxt;
  logic [CW-1:0]    rgb_nxt;

  // ---------------------------------------------------------------------------
  // Frame boundary: one-cycle pulse on the vsync falling edge. The history
  // register resets to 1 so a vsync held low through reset still produces
  // a boundary on the first clock after release.
  // ---------------------------------------------------------------------------
  assign frame_edge = vsync_d & ~vsync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d   <= 1'b1;
      frame_cnt <= 8'd0;
    end else begin
      vsync_d <= vsync;
      if (frame_edge) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Config FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // A commit that coincides with a boundary waits for the next one,
        // because PENDING only reacts to boundaries seen while in PENDING.
        if (cfg_commit) begin
          state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (frame_edge) begin
          state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign cfg_busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Shadow registers. They accept writes only in IDLE. A write issued
  // together with a commit still lands, so the commit includes it.
  // Indices at or above N_SRC match no entry and are dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        sh_x0[i] <= 10'd0;
        sh_x1[i] <= 10'd0;
        sh_y0[i] <= 10'd0;
        sh_y1[i] <= 10'd0;
        sh_en[i] <= 1'b0;
      end
    end else if (state == S_IDLE && cfg_wr) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cfg_idx == 2'(i)) begin
          sh_x0[i] <= cfg_x0;
          sh_x1[i] <= cfg_x1;
          sh_y0[i] <= cfg_y0;
          sh_y1[i] <= cfg_y1;
          sh_en[i] <= cfg_en;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active registers. The whole set is copied in the single APPLY cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        act_x0[i] <= 10'd0;
        act_x1[i] <= 10'd0;
        act_y0[i] <= 10'd0;
        act_y1[i] <= 10'd0;
        act_en[i] <= 1'b0;
      end
    end else if (state == S_APPLY) begin
      for (int i = 0; i < N_SRC; i++) begin
        act_x0[i] <= sh_x0[i];
        act_x1[i] <= sh_x1[i];
        act_y0[i] <= sh_y0[i];
        act_y1[i] <= sh_y1[i];
        act_en[i] <= sh_en[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window hit test. Inverted bounds (x0 > x1 or y0 > y1) can never satisfy
  // both compares, so such a window simply never hits.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hit[i] = act_en[i] &&
               (px >= act_x0[i]) && (px <= act_x1[i]) &&
               (py >= act_y0[i]) && (py <= act_y1[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Priority select. The loop scans from the highest index down, so the
  // lowest hitting index is the last to assign and wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_nxt = '0;
    rgb_nxt = '0;
    if (vidon) begin
      rgb_nxt = BG_COLOR;
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (hit[i]) begin
          gnt_nxt    = '0;
          gnt_nxt[i] = 1'b1;
          rgb_nxt    = src_rgb[i*CW +: CW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= '0;
      rgb_out <= '0;
    end else begin
      gnt     <= gnt_nxt;
      rgb_out <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_ventanas.sv
module tb_arbitro_ventanas;

  localparam int            N_SRC = 3;
  localparam int            CW    = 8;
  localparam logic [7:0]    BG    = 8'h3C;

  logic                clk = 1'b0;
  logic                rst;
  logic [9:0]          px, py;
  logic                vidon, vsync;
  logic [N_SRC*CW-1:0] src_rgb;
  logic                cfg_wr, cfg_en, cfg_commit;
  logic [1:0]          cfg_idx;
  logic [9:0]          cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  logic                cfg_busy;
  logic [N_SRC-1:0]    gnt;
  logic [CW-1:0]       rgb_out;
  logic [7:0]          frame_cnt;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_frame = 8'd0;

  arbitro_ventanas #(.N_SRC(N_SRC), .CW(CW), .BG_COLOR(BG)) dut (
    .clk        (clk),
    .rst        (rst),
    .px         (px),
    .py         (py),
    .vidon      (vidon),
    .vsync      (vsync),
    .src_rgb    (src_rgb),
    .cfg_wr     (cfg_wr),
    .cfg_idx    (cfg_idx),
    .cfg_x0     (cfg_x0),
    .cfg_x1     (cfg_x1),
    .cfg_y0     (cfg_y0),
    .cfg_y1     (cfg_y1),
    .cfg_en     (cfg_en),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .gnt        (gnt),
    .rgb_out    (rgb_out),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_win(input logic [1:0] idx, input logic [9:0] x0, input logic [9:0] x1,
                           input logic [9:0] y0, input logic [9:0] y1, input logic en,
                           input logic with_commit);
    cfg_idx = idx; cfg_x0 = x0; cfg_x1 = x1; cfg_y0 = y0; cfg_y1 = y1; cfg_en = en;
    cfg_wr = 1'b1;
    cfg_commit = with_commit;
    step();
    cfg_wr = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic pulse();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    exp_frame = exp_frame + 8'd1;
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic v,
                     input logic [7:0] exp_rgb, input logic [2:0] exp_gnt);
    px = x; py = y; vidon = v;
    step();
    check_val({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
    check_val({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
  endtask

  initial begin
    rst = 1'b0; px = '0; py = '0; vidon = 1'b0; vsync = 1'b1;
    src_rgb = {8'hCC, 8'h55, 8'hAA};
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0;

    // reset and defaults
    step(); step(); step();
    check_val("rst_gnt", 32'(gnt), 32'h0);
    check_val("rst_rgb", 32'(rgb_out), 32'h0);
    rst = 1'b1; vidon = 1'b1;
    step();
    check_val("post_rst_rgb", 32'(rgb_out), 32'(BG));
    check_val("post_rst_gnt", 32'(gnt), 32'h0);
    check_val("post_rst_busy", 32'(cfg_busy), 32'h0);
    check_val("post_rst_frame", 32'(frame_cnt), 32'h0);

    // single window
    write_win(2'd0, 10'd100, 10'd199, 10'd50, 10'd99, 1'b1, 1'b0);
    check_val("idle_busy", 32'(cfg_busy), 32'h0);
    commit();
    check_val("commit_busy", 32'(cfg_busy), 32'h1);
    vsync = 1'b0;
    step();
    check_val("apply_busy", 32'(cfg_busy), 32'h1);
    vsync = 1'b1;
    step();
    exp_frame = exp_frame + 8'd1;
    check_val("busy_drop", 32'(cfg_busy), 32'h0);
    check_val("frame1", 32'(frame_cnt), 32'(exp_frame));
    pix("w0_corner", 10'd100, 10'd50, 1'b1, 8'hAA, 3'b001);
    pix("w0_far", 10'd199, 10'd99, 1'b1, 8'hAA, 3'b001);
    pix("x200", 10'd200, 10'd50, 1'b1, BG, 3'b000);
    pix("x99", 10'd99, 10'd50, 1'b1, BG, 3'b000);
    pix("y100", 10'd100, 10'd100, 1'b1, BG, 3'b000);

    // priority overlap
    write_win(2'd1, 10'd140, 10'd160, 10'd55, 10'd65, 1'b1, 1'b0);
    commit();
    pulse();
    pix("ovl_w0", 10'd150, 10'd60, 1'b1, 8'hAA, 3'b001);
    write_win(2'd0, 10'd100, 10'd199, 10'd50, 10'd99, 1'b0, 1'b0);
    commit();
    pix("ovl_pend", 10'd150, 10'd60, 1'b1, 8'hAA, 3'b001);
    pulse();
    pix("ovl_w1", 10'd150, 10'd60, 1'b1, 8'h55, 3'b010);

    // tear-free and ignored write while busy
    write_win(2'd2, 10'd10, 10'd20, 10'd10, 10'd20, 1'b1, 1'b0);
    commit();
    write_win(2'd1, 10'd140, 10'd160, 10'd55, 10'd65, 1'b0, 1'b0);
    pix("tf_old_w2", 10'd15, 10'd15, 1'b1, BG, 3'b000);
    pix("tf_old_w1", 10'd150, 10'd60, 1'b1, 8'h55, 3'b010);
    pulse();
    pix("tf_new_w2", 10'd15, 10'd15, 1'b1, 8'hCC, 3'b100);
    pix("tf_kept_w1", 10'd150, 10'd60, 1'b1, 8'h55, 3'b010);
    check_val("frame_mid", 32'(frame_cnt), 32'(exp_frame));

    // write and commit in the same cycle
    write_win(2'd0, 10'd100, 10'd199, 10'd50, 10'd99, 1'b1, 1'b1);
    check_val("wc_busy", 32'(cfg_busy), 32'h1);
    pulse();
    pix("blank", 10'd150, 10'd60, 1'b0, 8'h00, 3'b000);
    pix("wc_w0", 10'd150, 10'd60, 1'b1, 8'hAA, 3'b001);

    // inverted window never hits
    write_win(2'd1, 10'd300, 10'd200, 10'd0, 10'd479, 1'b1, 1'b0);
    commit();
    pulse();
    pix("inv_250", 10'd250, 10'd60, 1'b1, BG, 3'b000);
    pix("inv_300", 10'd300, 10'd60, 1'b1, BG, 3'b000);
    pix("inv_200", 10'd200, 10'd60, 1'b1, BG, 3'b000);

    // commit in the same cycle as a boundary waits for the next one
    write_win(2'd2, 10'd10, 10'd20, 10'd10, 10'd20, 1'b0, 1'b0);
    cfg_commit = 1'b1; vsync = 1'b0;
    step();
    cfg_commit = 1'b0; vsync = 1'b1;
    step();
    exp_frame = exp_frame + 8'd1;
    step();
    check_val("edge_commit_busy", 32'(cfg_busy), 32'h1);
    pix("edge_commit_old", 10'd15, 10'd15, 1'b1, 8'hCC, 3'b100);
    pulse();
    check_val("edge_commit_done", 32'(cfg_busy), 32'h0);
    pix("edge_commit_new", 10'd15, 10'd15, 1'b1, BG, 3'b000);

    // frame counter wrap
    while (exp_frame != 8'd0) pulse();
    check_val("frame_wrap", 32'(frame_cnt), 32'h0);
    pulse();
    check_val("frame_after_wrap", 32'(frame_cnt), 32'h1);

    // reset while pending
    write_win(2'd0, 10'd100, 10'd199, 10'd50, 10'd99, 1'b1, 1'b0);
    commit();
    check_val("pend_busy", 32'(cfg_busy), 32'h1);
    rst = 1'b0;
    #1;
    check_val("async_busy", 32'(cfg_busy), 32'h0);
    check_val("async_frame", 32'(frame_cnt), 32'h0);
    check_val("async_rgb", 32'(rgb_out), 32'h0);
    step(); step();
    rst = 1'b1;
    exp_frame = 8'd0;
    step();
    pix("rst_cleared_w0", 10'd150, 10'd60, 1'b1, BG, 3'b000);
    commit();
    pulse();
    check_val("rst_frame", 32'(frame_cnt), 32'(exp_frame));
    pix("rst_shadow_w0", 10'd150, 10'd60, 1'b1, BG, 3'b000);
    pix("rst_shadow_w2", 10'd15, 10'd15, 1'b1, BG, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
